// File: rtl/decrypt_link_pkg.sv
// Shared constants and FSM state type for the serial AES-decrypt link.
package decrypt_link_pkg;
  localparam int BLK_W       = 128;
  localparam int CNT_W       = 7;
  localparam int TIMEOUT_CYC = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } host_state_e;
endpackage

// File: rtl/decrypt_serial_rx.sv
// Plaintext deserialiser: LSB-first shift-in on pt_vld, 128-bit framing,
// rx_done on the final sample and frame_err on an early drop of pt_vld.
module decrypt_serial_rx #(
  parameter int BLK_W = decrypt_link_pkg::BLK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_pt,
  input  logic             i_pt_vld,
  output logic [BLK_W-1:0] o_rx_data,
  output logic             o_rx_done,
  output logic             o_frame_err
);
  import decrypt_link_pkg::*;

  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-2:0] r_sh;
  logic [BLK_W-1:0] w_next;

  // Only the upper 127 bits are kept; the oldest bit falls out on each shift.
  assign w_next      = {i_pt, r_sh};
  assign o_rx_data   = w_next;
  assign o_rx_done   = !i_clr && i_pt_vld && (r_cnt == CNT_W'(BLK_W - 1));
  assign o_frame_err = !i_clr && !i_pt_vld && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_pt_vld) begin
      r_sh  <= w_next[BLK_W-1:1];
      r_cnt <= r_cnt + 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= '0;
    end
  end
endmodule

// File: rtl/decrypt_serial_host.sv
// Host endpoint of the serial decrypt link: serialises ct/rkey, collects plaintext.
// Optional WAIT watchdog enabled by defining DECRYPT_HOST_TIMEOUT_EN.
module decrypt_serial_host #(
  parameter int BLK_W       = decrypt_link_pkg::BLK_W,
  parameter int TIMEOUT_CYC = decrypt_link_pkg::TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BLK_W-1:0] ct_in,
  input  logic [BLK_W-1:0] rkey_in,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             ct,
  output logic             rkey,
  output logic             ct_rt_en,
  input  logic             pt,
  input  logic             pt_vld,
  output logic [BLK_W-1:0] pt_out,
  output logic             pt_out_valid,
  input  logic             pt_out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             timeout,
  input  logic             clr_err
);
  import decrypt_link_pkg::*;

  host_state_e      r_state;
  logic [BLK_W-1:0] r_ct_sh;
  logic [BLK_W-1:0] r_rkey_sh;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_ct_rt_en;
  logic [BLK_W-1:0] r_pt_out;
  logic             r_pt_out_valid;
  logic             r_overrun;
  logic             r_frame_err;

  logic [BLK_W-1:0] w_rx_data;
  logic             w_rx_done;
  logic             w_frame_evt;
  logic             w_ovr_evt;
  logic             w_to_fire;

  decrypt_serial_rx #(.BLK_W(BLK_W)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_to_fire),
    .i_pt       (pt),
    .i_pt_vld   (pt_vld),
    .o_rx_data  (w_rx_data),
    .o_rx_done  (w_rx_done),
    .o_frame_err(w_frame_evt)
  );

`ifdef DECRYPT_HOST_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  assign w_to_fire = (r_state == ST_WAIT) && !w_rx_done &&
                     (r_to_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == ST_WAIT) ? r_to_cnt + 1'b1 : '0;
      if (w_to_fire)    r_timeout <= 1'b1;
      else if (clr_err) r_timeout <= 1'b0;
    end
  end
  assign timeout = r_timeout;
`else
  assign w_to_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // Transmit FSM: a block shifts out over exactly 128 back-to-back cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ct_sh    <= '0;
      r_rkey_sh  <= '0;
      r_bit_cnt  <= '0;
      r_ct_rt_en <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (blk_valid) begin
            r_ct_sh    <= ct_in;
            r_rkey_sh  <= rkey_in;
            r_bit_cnt  <= '0;
            r_ct_rt_en <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_ct_sh   <= r_ct_sh >> 1;
          r_rkey_sh <= r_rkey_sh >> 1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(BLK_W - 1)) begin
            r_ct_rt_en <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_rx_done || w_to_fire) r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ct_rt_en <= 1'b0;
        end
      endcase
    end
  end

  assign w_ovr_evt = w_rx_done && r_pt_out_valid && !pt_out_ready;

  // Output buffer holds one plaintext block; a new one is dropped while it is unread.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pt_out       <= '0;
      r_pt_out_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      if (w_rx_done && (!r_pt_out_valid || pt_out_ready)) begin
        r_pt_out       <= w_rx_data;
        r_pt_out_valid <= 1'b1;
      end else if (r_pt_out_valid && pt_out_ready) begin
        r_pt_out_valid <= 1'b0;
      end
      if (w_ovr_evt)    r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (w_frame_evt)  r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
    end
  end

  assign blk_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign ct           = r_ct_sh[0];
  assign rkey         = r_rkey_sh[0];
  assign ct_rt_en     = r_ct_rt_en;
  assign pt_out       = r_pt_out;
  assign pt_out_valid = r_pt_out_valid;
  assign overrun      = r_overrun;
  assign frame_err    = r_frame_err;
endmodule

// File: tb/tb_decrypt_serial_host.sv
// Directed + randomized bench for decrypt_serial_host against a bit-vector reference.
module tb_decrypt_serial_host;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ct_in, rkey_in;
  logic         blk_valid, blk_ready;
  logic         ct, rkey, ct_rt_en;
  logic         pt, pt_vld;
  logic [127:0] pt_out;
  logic         pt_out_valid, pt_out_ready;
  logic         busy, overrun, frame_err, timeout, clr_err;

  int n_chk  = 0;
  int n_fail = 0;

  decrypt_serial_host #(.BLK_W(128), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst(rst), .ct_in(ct_in), .rkey_in(rkey_in),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .ct(ct), .rkey(rkey),
    .ct_rt_en(ct_rt_en), .pt(pt), .pt_vld(pt_vld), .pt_out(pt_out),
    .pt_out_valid(pt_out_valid), .pt_out_ready(pt_out_ready), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .timeout(timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer a block, then record every bit seen while ct_rt_en is high.
  task automatic send_block(input string tag, input logic [127:0] c, input logic [127:0] k);
    logic [127:0] cap_c, cap_k;
    int n, w;
    cap_c = '0; cap_k = '0; n = 0; w = 0;
    while (!blk_ready && w < 300) begin tick(); w++; end
    chk({tag, "_ready"}, 128'(blk_ready), 128'd1);
    ct_in = c; rkey_in = k; blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (!ct_rt_en) break;
      if (n < 128) begin cap_c[n] = ct; cap_k[n] = rkey; end
      n++;
      tick();
    end
    chk({tag, "_en_len"}, 128'(n), 128'd128);
    chk({tag, "_ct_bits"}, cap_c, c);
    chk({tag, "_rkey_bits"}, cap_k, k);
    chk({tag, "_wait_busy"}, {ct, rkey, busy, blk_ready}, {1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  // Drive len plaintext bits LSB first, then drop pt_vld.
  task automatic send_pt(input logic [127:0] d, input int len);
    for (int i = 0; i < len; i++) begin
      pt_vld = 1'b1; pt = d[i];
      tick();
    end
    pt_vld = 1'b0; pt = 1'b0;
  endtask

  task automatic consume();
    pt_out_ready = 1'b1;
    tick();
    chk("consume_valid_low", 128'(pt_out_valid), 128'd0);
    pt_out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] v_a, v_b, rc, rk, rp;
    rst = 1'b0; ct_in = '0; rkey_in = '0; blk_valid = 1'b0; pt = 1'b0; pt_vld = 1'b0;
    pt_out_ready = 1'b0; clr_err = 1'b0;
    #2;
    chk("rst_pt_out", pt_out, 128'd0);
    chk("rst_scalars", {ct, rkey, ct_rt_en, pt_out_valid, busy, overrun, frame_err, timeout, blk_ready},
        {8'b0, 1'b1});
    tick(); tick();
    rst = 1'b1;
    tick();

    send_block("bitorder", {1'b1, 126'd0, 1'b1}, 128'd0);

    v_a = 128'h0123456789abcdeffedcba9876543210;
    send_pt(v_a, 128);
    chk("rt_pt_out", pt_out, v_a);
    chk("rt_flags", {pt_out_valid, blk_ready, busy, frame_err}, 4'b1100);
    consume();

    for (int r = 0; r < 3; r++) begin
      rc = rand128(); rk = rand128(); rp = rand128();
      send_block("rand", rc, rk);
      send_pt(rp, 128);
      chk("rand_pt_out", pt_out, rp);
      chk("rand_valid", {pt_out_valid, blk_ready}, 2'b11);
      consume();
    end

    v_a = {16{8'hAA}}; v_b = {16{8'h55}};
    send_pt(v_a, 128);
    chk("ovr_first", pt_out, v_a);
    send_pt(v_b, 128);
    chk("ovr_kept", pt_out, v_a);
    chk("ovr_flag", {overrun, pt_out_valid}, 2'b11);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovr_clr", 128'(overrun), 128'd0);

    // Ready coincides with the final sample: new block replaces old, no overrun.
    rp = rand128();
    send_pt(rp, 127);
    pt_vld = 1'b1; pt = rp[127]; pt_out_ready = 1'b1;
    tick();
    pt_vld = 1'b0; pt = 1'b0; pt_out_ready = 1'b0;
    chk("swap_pt_out", pt_out, rp);
    chk("swap_flags", {pt_out_valid, overrun}, 2'b10);
    consume();

    send_pt(rand128(), 64);
    tick();
    chk("short_frame_err", {frame_err, pt_out_valid}, 2'b10);
    rp = rand128();
    send_pt(rp, 128);
    chk("after_short", pt_out, rp);
    chk("after_short_valid", 128'(pt_out_valid), 128'd1);
    consume();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("frame_clr", 128'(frame_err), 128'd0);

    send_block("to", rand128(), rand128());
`ifdef DECRYPT_HOST_TIMEOUT_EN
    for (int k = 1; k < 1000; k++) begin
      tick();
      if (k == 999) chk("to_pre", {timeout, busy}, 2'b01);
    end
    tick();
    chk("to_fire", {timeout, busy, blk_ready}, 3'b101);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("to_clr", 128'(timeout), 128'd0);
`else
    for (int k = 0; k < 1100; k++) tick();
    chk("no_to_busy", {timeout, busy}, 2'b01);
    rp = rand128();
    send_pt(rp, 128);
    chk("no_to_done", {busy, pt_out_valid}, 2'b01);
    chk("no_to_data", pt_out, rp);
    consume();
`endif

    ct_in = rand128(); rkey_in = rand128(); blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < 50; k++) tick();
    chk("mid_shift_en", 128'(ct_rt_en), 128'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {ct_rt_en, busy, blk_ready, ct}, 4'b0010);
    tick();
    rst = 1'b1;
    tick();
    send_block("post_rst", rand128(), rand128());
    rp = rand128();
    send_pt(rp, 128);
    chk("post_rst_rx", pt_out, rp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
